// File: rtl/add_pkg.sv
// Shared types and saturation constants for the pipelined adder/subtractor.
// The mode struct travels with every transaction through the pipeline.
package add_pkg;

   // Widest operand the saturation helpers can describe.
   localparam int MAX_W = 64;

   typedef struct packed {
      logic is_sub;
      logic is_sign;
      logic is_sat;
   } mode_t;

   function automatic logic [MAX_W-1:0] sat_smax(input int unsigned w);
      sat_smax = (64'd1 << (w - 1)) - 64'd1;
   endfunction

   function automatic logic [MAX_W-1:0] sat_smin(input int unsigned w);
      sat_smin = 64'd1 << (w - 1);
   endfunction

   function automatic logic [MAX_W-1:0] sat_umax(input int unsigned w);
      if (w >= MAX_W) sat_umax = '1;
      else            sat_umax = (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/add_sub_stage.sv
// One CHUNK-bit slice of the carry chain plus its pipeline register.
// The LAST slice also resolves overflow and saturation before registering.
module add_sub_stage
   import add_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int IDX   = 0,
   parameter bit LAST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             adv,
   input  logic             in_valid,
   input  mode_t            in_mode,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_carry,
   output logic             out_valid,
   output mode_t            out_mode,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_carry,
   output logic             out_ovf
);

   localparam int LO = IDX * CHUNK;
   localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_smax(WIDTH));
   localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_smin(WIDTH));
   localparam logic [WIDTH-1:0] UMAX = WIDTH'(sat_umax(WIDTH));

   logic [CHUNK:0]   slice;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] sat_val;
   logic [WIDTH-1:0] final_val;
   logic             ovf;

   // in_a[WIDTH-1] is still the original A sign bit here: the top slice
   // is the one being summed in this stage, so it has not been replaced yet.
   always_comb begin
      slice = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_b[LO +: CHUNK]}
            + {{CHUNK{1'b0}}, in_carry};
      sum = in_a;
      sum[LO +: CHUNK] = slice[CHUNK-1:0];
      if (in_mode.is_sign)
         ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      else
         ovf = in_mode.is_sub ? !slice[CHUNK] : slice[CHUNK];
      if (in_mode.is_sign)
         sat_val = in_a[WIDTH-1] ? SMIN : SMAX;
      else
         sat_val = in_mode.is_sub ? '0 : UMAX;
      final_val = (in_mode.is_sat && ovf) ? sat_val : sum;
   end

   // ---- stage register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         if (LAST) begin
            out_a     <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
         end
      end else if (adv) begin
         out_valid <= in_valid;
         out_mode  <= in_mode;
         out_a     <= LAST ? final_val : sum;
         out_b     <= in_b;
         out_carry <= slice[CHUNK];
         out_ovf   <= LAST ? ovf : 1'b0;
      end
   end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub: an input register followed by WIDTH/CHUNK slice stages,
// the last of which drives the outputs. One global stall freezes everything.
module add_sub_pipe
   import add_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_sub,
   input  logic             is_sign,
   input  logic             is_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             cout
);

   localparam int STAGES = WIDTH / CHUNK;

   if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("add_sub_pipe: WIDTH must be a multiple of CHUNK");
   end

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic             vld_p0;
   mode_t            mode_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             carry_p0;

   // ---- input register: B is pre-inverted and carry-in set for subtract ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
      end else if (adv) begin
         vld_p0   <= in_valid;
         mode_p0  <= mode_t'{is_sub, is_sign, is_sat};
         a_p0     <= a;
         b_p0     <= is_sub ? ~b : b;
         carry_p0 <= is_sub;
      end
   end

   logic             vld_p   [1:STAGES];
   mode_t            mode_p  [1:STAGES];
   logic [WIDTH-1:0] a_p     [1:STAGES];
   logic [WIDTH-1:0] b_p     [1:STAGES];
   logic             carry_p [1:STAGES];
   logic             ovf_p   [1:STAGES];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic             s_vld;
      mode_t            s_mode;
      logic [WIDTH-1:0] s_a;
      logic [WIDTH-1:0] s_b;
      logic             s_carry;

      if (k == 0) begin : g_first
         assign s_vld   = vld_p0;
         assign s_mode  = mode_p0;
         assign s_a     = a_p0;
         assign s_b     = b_p0;
         assign s_carry = carry_p0;
      end else begin : g_next
         assign s_vld   = vld_p[k];
         assign s_mode  = mode_p[k];
         assign s_a     = a_p[k];
         assign s_b     = b_p[k];
         assign s_carry = carry_p[k];
      end

      add_sub_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (k),
         .LAST  (k == STAGES - 1)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .adv       (adv),
         .in_valid  (s_vld),
         .in_mode   (s_mode),
         .in_a      (s_a),
         .in_b      (s_b),
         .in_carry  (s_carry),
         .out_valid (vld_p[k+1]),
         .out_mode  (mode_p[k+1]),
         .out_a     (a_p[k+1]),
         .out_b     (b_p[k+1]),
         .out_carry (carry_p[k+1]),
         .out_ovf   (ovf_p[k+1])
      );
   end

   assign out_valid = vld_p[STAGES];
   assign result    = a_p[STAGES];
   assign overflow  = ovf_p[STAGES];
   assign cout      = carry_p[STAGES];

   // Tail fields with no consumer past the final stage.
   logic unused_tail;
   always_comb begin
      unused_tail = (^b_p[STAGES]) ^ (^mode_p[STAGES]);
      for (int k = 1; k < STAGES; k++) unused_tail = unused_tail ^ ovf_p[k];
   end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: directed corner cases, randomized traffic with
// back-pressure against an arithmetic reference model, reset flush, 16-bit build.
module tb_add_sub_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        in_valid, in_ready, is_sub, is_sign, is_sat;
   logic        out_valid, out_ready, overflow, cout;
   logic [31:0] a, b, result;

   logic        in_valid16, in_ready16, is_sub16, is_sign16, is_sat16;
   logic        out_valid16, out_ready16, overflow16, cout16;
   logic [15:0] a16, b16, result16;

   int errors = 0;
   int checks = 0;

   typedef struct {
      longint unsigned res;
      bit              ovf;
      bit              cout;
   } exp_t;

   add_sub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_sub(is_sub), .is_sign(is_sign), .is_sat(is_sat),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow(overflow), .cout(cout)
   );

   add_sub_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .is_sub(is_sub16), .is_sign(is_sign16), .is_sat(is_sat16),
      .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
      .overflow(overflow16), .cout(cout16)
   );

   // Reference: true integer arithmetic, overflow = result out of range.
   function automatic exp_t model(input int w, input longint unsigned av, input longint unsigned bv,
                                  input bit sub, input bit sign, input bit sat);
      exp_t r;
      longint unsigned mask = (64'd1 << w) - 64'd1;
      longint sa, sb, full, smax, smin;
      av = av & mask;
      bv = bv & mask;
      sa = ((av >> (w - 1)) & 1) != 0 ? longint'(av) - longint'(64'd1 << w) : longint'(av);
      sb = ((bv >> (w - 1)) & 1) != 0 ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
      smax = longint'((64'd1 << (w - 1)) - 1);
      smin = -longint'(64'd1 << (w - 1));
      full = sub ? sa - sb : sa + sb;
      r.res  = (sub ? av - bv : av + bv) & mask;
      r.cout = sub ? (av >= bv) : ((av + bv) > mask);
      if (sign) r.ovf = (full > smax) || (full < smin);
      else      r.ovf = sub ? (av < bv) : ((av + bv) > mask);
      if (sat && r.ovf) begin
         if (sign) r.res = (full > smax) ? longint'(smax) : (longint'(smin) & longint'(mask));
         else      r.res = sub ? 64'd0 : mask;
      end
      return r;
   endfunction

   task automatic send32(input logic [31:0] av, input logic [31:0] bv, input bit s, input bit g,
                         input bit t, output logic [31:0] r, output logic o, output logic c,
                         output int lat);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; a = av; b = bv; is_sub = s; is_sign = g; is_sat = t;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin lat = i; break; end
      end
      r = result; o = overflow; c = cout;
   endtask

   task automatic send16(input logic [15:0] av, input logic [15:0] bv, input bit s, input bit g,
                         input bit t, output logic [15:0] r, output logic o, output int lat);
      @(posedge clk); #1;
      out_ready16 = 1'b1;
      in_valid16 = 1'b1; a16 = av; b16 = bv; is_sub16 = s; is_sign16 = g; is_sat16 = t;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (out_valid16) begin lat = i; break; end
      end
      r = result16; o = overflow16;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", result); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b want=0", cout); end
      checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid16 got=%b want=0", out_valid16); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_directed();
      logic [31:0] r;
      logic o, c;
      int lat;
      send32(32'hFFFFFF9C, 32'hFFFFFF9C, 1'b0, 1'b1, 1'b0, r, o, c, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d want=4", lat); end
      checks++; if (r !== 32'hFFFFFF38) begin errors++; $display("FAIL sadd_neg result got=%h want=ffffff38", r); end
      checks++; if (o !== 1'b0) begin errors++; $display("FAIL sadd_neg overflow got=%b want=0", o); end
      send32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b0, r, o, c, lat);
      checks++; if (r !== 32'h80000000) begin errors++; $display("FAIL sadd_ovf result got=%h want=80000000", r); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL sadd_ovf overflow got=%b want=1", o); end
      send32(32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 1'b1, r, o, c, lat);
      checks++; if (r !== 32'h7FFFFFFF) begin errors++; $display("FAIL sadd_sat result got=%h want=7fffffff", r); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL sadd_sat overflow got=%b want=1", o); end
      send32(32'd5, 32'd7, 1'b1, 1'b0, 1'b0, r, o, c, lat);
      checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL usub result got=%h want=fffffffe", r); end
      checks++; if (c !== 1'b0) begin errors++; $display("FAIL usub cout got=%b want=0", c); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL usub overflow got=%b want=1", o); end
      send32(32'd5, 32'd7, 1'b1, 1'b0, 1'b1, r, o, c, lat);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL usub_sat result got=%h want=00000000", r); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL usub_sat overflow got=%b want=1", o); end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h7FFFFFFF;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h0;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      exp_t q[$];
      exp_t e;
      int sent = 0, got = 0, extra = 0;
      bit pending = 1'b0, stall_prev = 1'b0;
      logic [31:0] held_r;
      logic held_o, held_c;
      for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
         @(posedge clk); #1;
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || result !== held_r || overflow !== held_o || cout !== held_c) begin
               errors++;
               $display("FAIL stall_hold got=%b/%h/%b/%b want=1/%h/%b/%b",
                        out_valid, result, overflow, cout, held_r, held_o, held_c);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pending) begin
            if (sent < 100 && $urandom_range(0, 4) != 0) begin
               in_valid = 1'b1;
               a = pick_operand(); b = pick_operand();
               {is_sub, is_sign, is_sat} = 3'(sent % 8);
            end else begin
               in_valid = 1'b0;
            end
         end
         #1;
         if (in_valid && in_ready) begin
            q.push_back(model(32, a, b, is_sub, is_sign, is_sat));
            sent++;
            pending = 1'b0;
         end else begin
            pending = in_valid;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_unexpected got=%h want=no_output", result);
            end else begin
               e = q.pop_front();
               if (result !== e.res[31:0] || overflow !== e.ovf || cout !== e.cout) begin
                  errors++;
                  $display("FAIL rand_txn%0d got=%h/%b/%b want=%h/%b/%b",
                           got, result, overflow, cout, e.res[31:0], e.ovf, e.cout);
               end
            end
            got++;
         end
         stall_prev = out_valid && !out_ready;
         held_r = result; held_o = overflow; held_c = cout;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      checks++; if (got !== 100) begin errors++; $display("FAIL rand_count got=%0d want=100", got); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL rand_duplicate got=%0d want=0", extra); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] r;
      logic o, c;
      int lat;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = $urandom; b = $urandom;
         is_sub = 1'b0; is_sign = 1'b0; is_sat = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle%0d out_valid got=%b want=0", i, out_valid); end
         @(posedge clk); #1;
      end
      send32(32'd1000, 32'd234, 1'b1, 1'b1, 1'b0, r, o, c, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL after_reset latency got=%0d want=4", lat); end
      checks++; if (r !== 32'd766) begin errors++; $display("FAIL after_reset result got=%0d want=766", r); end
   endtask

   task automatic test_w16();
      logic [15:0] r;
      logic o;
      int lat;
      send16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, r, o, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL w16 latency got=%0d want=4", lat); end
      checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL w16_ssub result got=%h want=7fff", r); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL w16_ssub overflow got=%b want=1", o); end
      send16(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, r, o, lat);
      checks++; if (r !== 16'h8000) begin errors++; $display("FAIL w16_sat result got=%h want=8000", r); end
      checks++; if (o !== 1'b1) begin errors++; $display("FAIL w16_sat overflow got=%b want=1", o); end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; is_sub = 1'b0; is_sign = 1'b0; is_sat = 1'b0;
      out_ready = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; is_sub16 = 1'b0; is_sign16 = 1'b0; is_sat16 = 1'b0;
      out_ready16 = 1'b1;
      test_reset();
      test_directed();
      test_random();
      test_reset_midflight();
      test_w16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
